// File: rtl/prbs_seed_sequencer_if.sv
// Bundle between the seed sequencer, its configuration source and the PRBS datapath.
// cfg_we and start are single-cycle strobes sampled on the rising clock edge; there is no back-pressure.
interface prbs_seed_sequencer_if #(
    parameter int SIZE  = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
);
    localparam int IW = $clog2(DEPTH);

    logic             cfg_we;
    logic [IW-1:0]    cfg_addr;
    logic [SIZE-1:0]  cfg_seed;
    logic [CNT_W-1:0] cfg_len;
    logic [IW:0]      num_runs;
    logic             start;
    logic             abort;
    logic             prbs_in;

    logic             set_seed;
    logic [SIZE-1:0]  seed;
    logic             busy;
    logic [IW-1:0]    run_idx;
    logic [CNT_W-1:0] run_ones;
    logic             run_valid;
    logic             done;
    logic             zero_seed_err;
    logic [2:0]       dbg_state;

    modport master (
        output cfg_we, cfg_addr, cfg_seed, cfg_len, num_runs, start, abort, prbs_in,
        input  set_seed, seed, busy, run_idx, run_ones, run_valid, done, zero_seed_err, dbg_state
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_seed, cfg_len, num_runs, start, abort, prbs_in,
        output set_seed, seed, busy, run_idx, run_ones, run_valid, done, zero_seed_err, dbg_state
    );
endinterface

// File: rtl/prbs_seed_sequencer.sv
// Walks a PRBS generator through a table of seeds, running each for a programmed
// number of clocks and reporting how many ones it produced.
module prbs_seed_sequencer #(
    parameter int              SIZE         = 8,
    parameter int              DEPTH        = 4,
    parameter int              CNT_W        = 16,
    parameter logic [SIZE-1:0] DEFAULT_SEED = {{(SIZE-1){1'b0}}, 1'b1}
) (
    input  logic                  clock,
    input  logic                  reset,
    prbs_seed_sequencer_if.slave  bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int NW = IW + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RUN    = 3'd2;
    localparam logic [2:0] S_REPORT = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [SIZE-1:0]  tab_seed_q [DEPTH];
    logic [CNT_W-1:0] tab_len_q  [DEPTH];
    logic [IW-1:0]    run_idx_q, run_idx_d;
    logic [NW-1:0]    nruns_q, nruns_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0] run_ones_q, run_ones_d;
    logic [SIZE-1:0]  seed_q, seed_d;
    logic             zerr_q, zerr_d;

    logic [NW-1:0]    nruns_sat;
    logic [SIZE-1:0]  cur_seed;
    logic [SIZE-1:0]  load_seed;
    logic [CNT_W-1:0] cur_len;
    logic             last_run;
    logic             busy;
    logic             kill;

    assign busy      = (state_q != S_IDLE);
    assign kill      = busy && bus.abort;
    assign nruns_sat = (bus.num_runs > NW'(DEPTH)) ? NW'(DEPTH) : bus.num_runs;
    assign cur_seed  = tab_seed_q[run_idx_q];
    assign cur_len   = tab_len_q[run_idx_q];
    // An all-zero seed would lock the LFSR, so the default is loaded instead.
    assign load_seed = (cur_seed == '0) ? DEFAULT_SEED : cur_seed;
    assign last_run  = ({1'b0, run_idx_q} == (nruns_q - NW'(1)));

    always_comb begin
        state_d    = state_q;
        run_idx_d  = run_idx_q;
        nruns_d    = nruns_q;
        len_d      = len_q;
        ones_d     = ones_q;
        run_ones_d = run_ones_q;
        seed_d     = seed_q;
        zerr_d     = zerr_q;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        nruns_d   = nruns_sat;
                        run_idx_d = '0;
                        zerr_d    = 1'b0;
                        state_d   = (nruns_sat == '0) ? S_FIN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    seed_d = load_seed;
                    if (cur_seed == '0) begin
                        zerr_d = 1'b1;
                    end
                    len_d  = cur_len;
                    ones_d = '0;
                    if (cur_len == '0) begin
                        run_ones_d = '0;
                        state_d    = S_REPORT;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    ones_d = ones_q + {{(CNT_W-1){1'b0}}, bus.prbs_in};
                    len_d  = len_q - CNT_W'(1);
                    // Result is captured on the last RUN edge so it is visible during REPORT.
                    if (len_q == CNT_W'(1)) begin
                        run_ones_d = ones_d;
                        state_d    = S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (last_run) begin
                        state_d = S_FIN;
                    end else begin
                        run_idx_d = run_idx_q + IW'(1);
                        state_d   = S_LOAD;
                    end
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            run_idx_q  <= '0;
            nruns_q    <= '0;
            len_q      <= '0;
            ones_q     <= '0;
            run_ones_q <= '0;
            seed_q     <= DEFAULT_SEED;
            zerr_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tab_seed_q[i] <= DEFAULT_SEED;
                tab_len_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            run_idx_q  <= run_idx_d;
            nruns_q    <= nruns_d;
            len_q      <= len_d;
            ones_q     <= ones_d;
            run_ones_q <= run_ones_d;
            seed_q     <= seed_d;
            zerr_q     <= zerr_d;
            if (bus.cfg_we && !busy) begin
                tab_seed_q[bus.cfg_addr] <= bus.cfg_seed;
                tab_len_q[bus.cfg_addr]  <= bus.cfg_len;
            end
        end
    end

    assign bus.set_seed      = (state_q == S_LOAD) && !bus.abort;
    assign bus.seed          = (state_q == S_LOAD) ? load_seed : seed_q;
    assign bus.busy          = busy;
    assign bus.run_idx       = run_idx_q;
    assign bus.run_ones      = run_ones_q;
    assign bus.run_valid     = (state_q == S_REPORT) && !bus.abort;
    assign bus.done          = (state_q == S_FIN) && !bus.abort;
    assign bus.zero_seed_err = zerr_q;
    assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_prbs_seed_sequencer.sv
// Bench for prbs_seed_sequencer: table of sequence records plus a scoreboard of
// expected seed loads and run results, checked as the DUT pulses set_seed/run_valid.
module tb_prbs_seed_sequencer;
    localparam int SIZE  = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    typedef struct {
        logic [3:0][7:0]  seed;
        logic [3:0][15:0] len;
        logic [3:0]       wr_mask;
        bit               wr_with_start;
        int               nruns;
        bit               alt;
        int               kill_at;
        bit               kill_rst;
        bit               wr_busy;
        logic [3:0][15:0] exp_ones;
        bit               exp_zerr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    prbs_seed_sequencer_if #(.SIZE(SIZE), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    prbs_seed_sequencer #(.SIZE(SIZE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   pidx = 0;
    int   base = 0;
    int   done_cnt = 0;
    int   done_off = 0;
    int   kill_at = -1;
    bit   kill_rst = 1'b0;
    bit   wr_busy = 1'b0;
    bit   alt_mode = 1'b0;
    bit   rst_force = 1'b1;
    logic [7:0]  tb_seed [4];
    logic [15:0] tb_len  [4];
    logic [15:0] last_ones;

    logic [7:0]  exp_seed_q [$];
    logic [15:0] exp_ld_q   [$];
    logic [15:0] exp_ones_q [$];
    logic [1:0]  exp_idx_q  [$];
    logic [15:0] exp_rv_q   [$];

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (offset %0d)", name, act, exp, cyc - base);
        end
    endtask

    function automatic logic pat_bit(input int j);
        return alt_mode ? logic'(j % 2 == 0) : 1'b1;
    endfunction

    function automatic logic [15:0] alt_ones(input int lo, input int len);
        logic [15:0] c = 0;
        for (int j = lo; j < lo + len; j++) if (j % 2 == 0) c++;
        return c;
    endfunction

    task automatic monitor();
        if (bus.set_seed) begin
            if (exp_seed_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL set_seed_unexpected: actual=1 expected=0 (offset %0d)", cyc - base);
            end else begin
                chk("load_seed", 32'(bus.seed), 32'(exp_seed_q.pop_front()));
                chk("load_offset", cyc - base, 32'(exp_ld_q.pop_front()));
            end
        end
        if (bus.run_valid) begin
            if (exp_ones_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL run_valid_unexpected: actual=1 expected=0 (offset %0d)", cyc - base);
            end else begin
                chk("run_ones", 32'(bus.run_ones), 32'(exp_ones_q.pop_front()));
                chk("run_idx", 32'(bus.run_idx), 32'(exp_idx_q.pop_front()));
                chk("report_offset", cyc - base, 32'(exp_rv_q.pop_front()));
            end
        end
        if (bus.done) begin
            done_cnt++;
            done_off = cyc - base;
        end
    endtask

    // Inputs move 1 time unit after the rising edge; outputs are checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        pidx++;
        bus.prbs_in = pat_bit(pidx);
        bus.start   = 1'b0;
        bus.abort   = (kill_at >= 0) && (pidx == kill_at) && !kill_rst;
        rst         = rst_force || ((kill_at >= 0) && (pidx == kill_at) && kill_rst);
        if (wr_busy && pidx == 2) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_seed = 8'hAA; bus.cfg_len = 16'd9;
        end else begin
            bus.cfg_we = 1'b0;
        end
        @(negedge clk);
        if (!rst) monitor();
    endtask

    task automatic write_entry(input int a, input logic [7:0] s, input logic [15:0] l);
        bus.cfg_we = 1'b1; bus.cfg_addr = 2'(a); bus.cfg_seed = s; bus.cfg_len = l;
        tb_seed[a] = s; tb_len[a] = l;
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_set_seed"}, 32'(bus.set_seed), 0);
        chk({tag, "_seed"}, 32'(bus.seed), 32'h01);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_run_idx"}, 32'(bus.run_idx), 0);
        chk({tag, "_run_ones"}, 32'(bus.run_ones), 0);
        chk({tag, "_run_valid"}, 32'(bus.run_valid), 0);
        chk({tag, "_done"}, 32'(bus.done), 0);
        chk({tag, "_zerr"}, 32'(bus.zero_seed_err), 0);
        chk({tag, "_state"}, 32'(bus.dbg_state), 0);
    endtask

    task automatic run_seq(input vec_t v);
        int n, acc, ld, rv;
        for (int i = 0; i < 4; i++)
            if (v.wr_mask[i] && !(v.wr_with_start && i == 0)) write_entry(i, v.seed[i], v.len[i]);
        n        = (v.nruns > DEPTH) ? DEPTH : v.nruns;
        kill_at  = v.kill_at;
        kill_rst = v.kill_rst;
        wr_busy  = v.wr_busy;
        alt_mode = v.alt;
        if (v.wr_with_start) begin
            bus.cfg_we = 1'b1; bus.cfg_addr = 2'd0; bus.cfg_seed = v.seed[0]; bus.cfg_len = v.len[0];
            tb_seed[0] = v.seed[0]; tb_len[0] = v.len[0];
        end
        done_cnt = 0;
        acc = 0;
        for (int r = 0; r < n; r++) begin
            ld = 1 + acc;
            rv = ld + 1 + int'(tb_len[r]);
            if (kill_at < 0 || ld < kill_at) begin
                exp_seed_q.push_back((tb_seed[r] == 8'h00) ? 8'h01 : tb_seed[r]);
                exp_ld_q.push_back(16'(ld));
            end
            if (kill_at < 0 || rv < kill_at) begin
                exp_ones_q.push_back(v.exp_ones[r]);
                exp_idx_q.push_back(2'(r));
                exp_rv_q.push_back(16'(rv));
                last_ones = v.exp_ones[r];
            end
            acc += int'(tb_len[r]) + 2;
        end
        bus.num_runs = v.nruns[2:0];
        bus.start    = 1'b1;
        pidx         = 0;
        bus.prbs_in  = pat_bit(0);
        base         = cyc;
        tick();
        chk("zerr_clear_on_start", 32'(bus.zero_seed_err), 0);
        if (kill_at < 0) begin
            while (done_cnt == 0 && pidx < acc + 20) tick();
            chk("done_offset", done_off, 1 + acc);
            tick();
            chk("done_count", done_cnt, 1);
            chk("busy_after_done", 32'(bus.busy), 0);
            chk("zero_seed_err", 32'(bus.zero_seed_err), 32'(v.exp_zerr));
            repeat (3) tick();
            chk("zero_seed_err_held", 32'(bus.zero_seed_err), 32'(v.exp_zerr));
        end else begin
            while (pidx < kill_at + 1) tick();
            if (kill_rst) begin
                check_reset_outputs("mid_reset");
                for (int i = 0; i < 4; i++) begin tb_seed[i] = 8'h01; tb_len[i] = 16'd0; end
            end else begin
                chk("busy_after_abort", 32'(bus.busy), 0);
                chk("run_ones_after_abort", 32'(bus.run_ones), 32'(last_ones));
            end
            repeat (5) tick();
            chk("no_done_after_kill", done_cnt, 0);
        end
        chk("pending_loads", exp_seed_q.size(), 0);
        chk("pending_reports", exp_ones_q.size(), 0);
        exp_seed_q.delete(); exp_ld_q.delete();
        exp_ones_q.delete(); exp_idx_q.delete(); exp_rv_q.delete();
        kill_at = -1; kill_rst = 1'b0; wr_busy = 1'b0;
        tick();
    endtask

    task automatic set_vec(input int i, input logic [31:0] seeds, input logic [63:0] lens,
                           input logic [3:0] mask, input int nruns, input bit alt,
                           input logic [63:0] exp, input bit zerr);
        vecs[i].seed = seeds;          vecs[i].len = lens;
        vecs[i].wr_mask = mask;        vecs[i].wr_with_start = 1'b0;
        vecs[i].nruns = nruns;         vecs[i].alt = alt;
        vecs[i].kill_at = -1;          vecs[i].kill_rst = 1'b0;
        vecs[i].wr_busy = 1'b0;        vecs[i].exp_ones = exp;
        vecs[i].exp_zerr = zerr;
    endtask

    initial begin
        int n, acc, ld;
        bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_seed = 0; bus.cfg_len = 0;
        bus.num_runs = 0; bus.start = 0; bus.abort = 0; bus.prbs_in = 0;
        for (int i = 0; i < 4; i++) begin tb_seed[i] = 8'h01; tb_len[i] = 16'd0; end
        last_ones = 0;

        //          seeds {e3,e2,e1,e0}   lens {e3,e2,e1,e0}                     mask nr alt exp_ones {r3,r2,r1,r0}                 zerr
        set_vec(0,  {8'h0, 8'h0, 8'h0, 8'h0F},  {16'd0, 16'd0, 16'd0, 16'd8},   4'h1, 1, 0, {16'd0, 16'd0, 16'd0, 16'd8},   0);
        set_vec(1,  {8'h0, 8'h62, 8'h49, 8'h0F}, {16'd0, 16'd3, 16'd6, 16'd4},  4'h7, 3, 1, {16'd0, 16'd2, 16'd3, 16'd2},   0);
        set_vec(2,  {8'h0, 8'h0, 8'h00, 8'h0F}, {16'd0, 16'd0, 16'd5, 16'd4},   4'h3, 2, 0, {16'd0, 16'd0, 16'd5, 16'd4},   1);
        set_vec(3,  {8'h0, 8'h0, 8'h0, 8'h33},  {16'd0, 16'd0, 16'd0, 16'd0},   4'h1, 1, 0, {16'd0, 16'd0, 16'd0, 16'd0},   0);
        set_vec(4,  {8'h0, 8'h0, 8'h0, 8'h0},   {16'd0, 16'd0, 16'd0, 16'd0},   4'h0, 0, 0, {16'd0, 16'd0, 16'd0, 16'd0},   0);
        set_vec(5,  {8'h44, 8'h33, 8'h22, 8'h11}, {16'd5, 16'd1, 16'd3, 16'd2}, 4'hF, 7, 0, {16'd5, 16'd1, 16'd3, 16'd2},   0);
        set_vec(6,  {8'h0, 8'h0, 8'h49, 8'h0F}, {16'd0, 16'd0, 16'd6, 16'd4},   4'h3, 2, 0, {16'd0, 16'd0, 16'd6, 16'd4},   0);
        set_vec(7,  {8'h0, 8'h0, 8'h0, 8'h0},   {16'd0, 16'd0, 16'd0, 16'd0},   4'h0, 2, 0, {16'd0, 16'd0, 16'd6, 16'd4},   0);
        set_vec(10, {8'h0, 8'h0, 8'h0, 8'h5A},  {16'd0, 16'd0, 16'd0, 16'd8},   4'h1, 1, 0, {16'd0, 16'd0, 16'd0, 16'd0},   0);
        set_vec(11, {8'h0, 8'h0, 8'h0, 8'h0},   {16'd0, 16'd0, 16'd0, 16'd0},   4'h0, 4, 0, {16'd0, 16'd0, 16'd0, 16'd0},   0);
        vecs[5].wr_with_start = 1'b1;
        vecs[6].kill_at = 10; vecs[6].wr_busy = 1'b1;
        vecs[10].kill_at = 4; vecs[10].kill_rst = 1'b1;
        for (int i = 8; i < 10; i++) begin
            set_vec(i, 0, 0, 4'hF, $urandom_range(1, 5), 1, 0, 0);
            for (int e = 0; e < 4; e++) begin
                vecs[i].seed[e] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                vecs[i].len[e]  = 16'($urandom_range(0, 10));
            end
            n = (vecs[i].nruns > DEPTH) ? DEPTH : vecs[i].nruns;
            acc = 0;
            for (int r = 0; r < n; r++) begin
                ld = 1 + acc;
                vecs[i].exp_ones[r] = alt_ones(ld + 1, int'(vecs[i].len[r]));
                if (vecs[i].seed[r] == 8'h00) vecs[i].exp_zerr = 1'b1;
                acc += int'(vecs[i].len[r]) + 2;
            end
        end

        repeat (3) tick();
        check_reset_outputs("reset");
        rst_force = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) run_seq(vecs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/prbs_seed_sequencer.md
Name: prbs_seed_sequencer

Overview:
- Controller that sequences an external PRBS generator through a programmed table of seeds.
- For each table entry it loads the seed into the generator via its set_seed/seed load port, lets it run for a programmed number of clocks, and counts the ones on the generator's output bit.
- It reports one result per run and signals completion.
- Sits between a config/CSR interface and the prbs datapath. Used for repeatable multi-seed pattern tests.

Parameters:
- SIZE, 8, LFSR width; width of seed.
- DEPTH, 4, number of seed-table entries (power of 2, ≥2).
- CNT_W, 16, width of run length and ones counter.
- DEFAULT_SEED, 8'h01, substituted when a table seed is all-zero (width SIZE, must be nonzero).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe; ignored while busy.
- cfg_addr  in  $clog2(DEPTH)  table entry index.
- cfg_seed  in  SIZE  seed written to entry.
- cfg_len  in  CNT_W  run length (clocks) written to entry.
- num_runs  in  $clog2(DEPTH)+1  entries to execute (0..DEPTH), sampled on start.
- start  in  1  begin sequence; honoured only in IDLE.
- abort  in  1  terminate sequence; returns to IDLE.
- prbs_in  in  1  output bit of the PRBS generator.
- set_seed  out  1  load strobe to generator.
- seed  out  SIZE  seed value to generator.
- busy  out  1  high in any state except IDLE.
- run_idx  out  $clog2(DEPTH)  entry currently / last executed.
- run_ones  out  CNT_W  ones count of the completed run.
- run_valid  out  1  one-cycle pulse: run_ones/run_idx valid.
- done  out  1  one-cycle pulse at sequence end (not on abort).
- zero_seed_err  out  1  sticky: an all-zero seed was substituted; cleared by reset or next start.

Behaviour:
- Reset (sync, active-high): state IDLE. All outputs 0, except seed=DEFAULT_SEED. Table contents are cleared to seed=DEFAULT_SEED, len=0.
- Table writes complete in one cycle when cfg_we=1 and busy=0. A write while busy is dropped.
- FSM states: IDLE, LOAD, RUN, REPORT, FIN.
- IDLE: when start=1 at edge k:
  - num_runs latched; run_idx←0; zero_seed_err←0.
  - If num_runs=0 → FIN, otherwise → LOAD.
- LOAD (exactly one cycle): set_seed=1; seed=table[run_idx].seed, or DEFAULT_SEED if that value is 0 (in which case zero_seed_err←1). Length counter loaded with table len; ones counter cleared. Next state: RUN if len≠0, else REPORT.
- RUN: set_seed=0; seed holds its value. Each cycle, ones += prbs_in and length counter decrements. After len cycles → REPORT.
- REPORT (one cycle): run_valid=1; run_ones=count (held until the next REPORT). If run_idx = num_runs−1 → FIN, else run_idx+1 and → LOAD.
- FIN (one cycle): done=1; → IDLE.
- Sequence latency: start at edge k gives the first set_seed in cycle k+1, RUN cycles k+2..k+1+len0, and run_valid in cycle k+2+len0. Each run costs len+2 cycles; the sequence ends with 1 FIN cycle.
- Counter width: the ones counter cannot overflow because count ≤ len < 2^CNT_W.
- num_runs > DEPTH is saturated to DEPTH.
- Abort wins over all other events in any non-IDLE state: next state is IDLE, set_seed=0, no run_valid, no done. run_ones retains the last reported value.
- Abort in IDLE has no effect.
- start while busy is ignored.
- Simultaneous start and cfg_we in IDLE: the write lands, and the sequence uses the new value if it is the same entry.
- Reset mid-sequence behaves as abort and additionally clears the table.

Test Plan:
- Table e0={0x0F,8}; prbs_in=1; num_runs=1; start at edge k → set_seed=1 and seed=0x0F in cycle k+1; run_valid in k+10 with run_ones=8, run_idx=0; done in k+11; busy low at k+12.
- Entries e0={0x0F,4}, e1={0x49,6}, e2={0x62,3}; prbs_in alternating 1,0 starting at 1; num_runs=3 → three set_seed pulses with seeds 0x0F, 0x49, 0x62; run_ones = 2, 3, 2; done once.
- e1.seed=0x00, len=5 → seed=DEFAULT_SEED (0x01) during that LOAD; zero_seed_err=1 and held; the next start clears it.
- e0.len=0; num_runs=1 → LOAD → REPORT with run_ones=0 → FIN; 3 cycles total. num_runs=0 → done the cycle after start, with no set_seed.
- Abort asserted in the 3rd RUN cycle of run 1 → IDLE next cycle; no run_valid/done for run 1. cfg_we while busy leaves the table unchanged, checked by rerunning the sequence.
- Reset asserted mid-RUN → all outputs 0 next cycle, seed=0x01; table entries read back as {0x01,0}, checked via a run.
